code_lock: RTL and testbench

Parametrised serial code lock with a programmable code length and value, a failed-attempt counter, timed auto-relock and an alarm lockout. It accepts one code bit per qualified clock. Each frame of CODE_LEN bits is compared against the CODE parameter, and the block drives a registered unlock pulse of fixed duration. It sits between the keypad/serial front end and the door actuator driver.

---
 rtl/code_lock.sv | 125 ++++++++++++
 tb/tb_code_lock.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock.sv
// Serial code lock: collects CODE_LEN-bit frames MSB-first and compares them against CODE.
// A match gives a timed unlock pulse; MAX_FAIL consecutive misses give a timed alarm lockout.
module code_lock #(
  parameter int unsigned          CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0]  CODE           = 4'b1010,
  parameter int unsigned          MAX_FAIL       = 3,
  parameter int unsigned          UNLOCK_CYCLES  = 8,
  parameter int unsigned          LOCKOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            code_valid,
  input  logic                            code_in,
  input  logic                            lock_now,
  output logic                            unlocked,
  output logic                            alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count,
  output logic [$clog2(CODE_LEN+1)-1:0]   bit_count
);

  localparam int unsigned FC_W    = $clog2(MAX_FAIL + 1);
  localparam int unsigned BC_W    = $clog2(CODE_LEN + 1);
  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [BC_W-1:0]  LAST_BIT     = BC_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]  FAIL_LIMIT   = FC_W'(MAX_FAIL);
  localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  state_t              state;
  logic [CODE_LEN-2:0] shreg;
  logic [TMR_W-1:0]    timer;
  logic [CODE_LEN-1:0] frame;
  logic [FC_W-1:0]     fail_next;

  // Saturating increment; the lockout transition keeps it from ever exceeding MAX_FAIL.
  function automatic logic [FC_W-1:0] fail_inc(input logic [FC_W-1:0] f);
    return (f == FAIL_LIMIT) ? f : f + FC_W'(1);
  endfunction

  // The completed frame includes the bit being sampled on this edge.
  assign frame     = {shreg, code_in};
  assign fail_next = fail_inc(fail_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_count  <= '0;
      fail_count <= '0;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_now) begin
            shreg     <= '0;
            bit_count <= '0;
          end else if (code_valid) begin
            if (bit_count == LAST_BIT) begin
              shreg     <= '0;
              bit_count <= '0;
              if (frame == CODE) begin
                state      <= UNLOCKED;
                unlocked   <= 1'b1;
                fail_count <= '0;
                timer      <= UNLOCK_LOAD;
              end else if (fail_next == FAIL_LIMIT) begin
                state      <= LOCKOUT;
                alarm      <= 1'b1;
                fail_count <= fail_next;
                timer      <= LOCKOUT_LOAD;
              end else begin
                fail_count <= fail_next;
              end
            end else begin
              shreg     <= frame[CODE_LEN-2:0];
              bit_count <= bit_count + BC_W'(1);
            end
          end
        end

        // Timer counts down to 1; the edge that sees 1 ends the pulse, giving exactly N high cycles.
        UNLOCKED: begin
          if (lock_now || timer == TMR_LAST) begin
            state    <= IDLE;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end

        LOCKOUT: begin
          if (timer == TMR_LAST) begin
            state      <= IDLE;
            alarm      <= 1'b0;
            fail_count <= '0;
            bit_count  <= '0;
            timer      <= '0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          unlocked <= 1'b0;
          alarm    <= 1'b0;
          timer    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock.sv
// Scoreboard bench for code_lock: stimulus queues expected unlock/alarm pulses,
// a monitor measures each pulse (start cycle, length, fail_count at start) and compares.
module tb_code_lock;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic       code_in = 1'b0;
  logic       lock_now = 1'b0;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fail_count;
  logic [2:0] bit_count;

  code_lock #(
    .CODE_LEN(4), .CODE(4'b1010), .MAX_FAIL(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in),
    .lock_now(lock_now), .unlocked(unlocked), .alarm(alarm),
    .fail_count(fail_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = unlock pulse, 1 = alarm pulse
    int rise;
    int len;
    int fail;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report(input int kind, input int rise, input int len, input int fail);
    ev_t e;
    string nm;
    nm = (kind == 0) ? "unlock" : "alarm";
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected_pulse"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_kind"}, kind, e.kind);
    chk({nm, "_rise_cycle"}, rise, e.rise);
    chk({nm, "_length"}, len, e.len);
    chk({nm, "_fail_at_rise"}, fail, e.fail);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic pu, pa;
    int   rise_u, rise_a, len_u, len_a, fail_u, fail_a;
    pu = 1'b0; pa = 1'b0;
    rise_u = 0; rise_a = 0; len_u = 0; len_a = 0; fail_u = 0; fail_a = 0;
    forever begin
      @(negedge clk);
      if (unlocked === 1'b1 && pu !== 1'b1) begin rise_u = cyc; len_u = 0; fail_u = int'(fail_count); end
      if (unlocked === 1'b1) len_u++;
      if (unlocked !== 1'b1 && pu === 1'b1) report(0, rise_u, len_u, fail_u);
      pu = unlocked;
      if (alarm === 1'b1 && pa !== 1'b1) begin rise_a = cyc; len_a = 0; fail_a = int'(fail_count); end
      if (alarm === 1'b1) len_a++;
      if (alarm !== 1'b1 && pa === 1'b1) report(1, rise_a, len_a, fail_a);
      pa = alarm;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    code_valid = 1'b1;
    code_in    = b;
    tick(1);
    code_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] f);
    for (int i = 3; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic expect_pulse(input int kind, input int rise, input int len, input int fail);
    ev_t e;
    e.kind = kind; e.rise = rise; e.len = len; e.fail = fail;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_unlocked"}, int'(unlocked), 0);
    chk({tag, "_alarm"}, int'(alarm), 0);
    chk({tag, "_fail_count"}, int'(fail_count), 0);
    chk({tag, "_bit_count"}, int'(bit_count), 0);
  endtask

  initial begin
    int k;
    // Reset state
    tick(2);
    chk_zero("reset");
    reset = 1'b0;
    tick(1);

    // Correct code; a bit arriving on the timer-expiry edge is ignored
    send_frame(4'b1010);
    k = cyc;
    expect_pulse(0, k, 8, 0);
    chk("s1_fail_count", int'(fail_count), 0);
    chk("s1_bit_count", int'(bit_count), 0);
    tick(7);
    send_bit(1'b1);
    chk("s1_expiry_bit_ignored", int'(bit_count), 0);
    chk("s1_relocked", int'(unlocked), 0);

    // Wrong then right
    send_frame(4'b1111);
    chk("s2_fail_after_wrong", int'(fail_count), 1);
    chk("s2_no_unlock", int'(unlocked), 0);
    send_frame(4'b1010);
    expect_pulse(0, cyc, 8, 0);
    chk("s2_fail_cleared", int'(fail_count), 0);
    tick(9);

    // Gaps and abort (fail_count held across abort)
    send_frame(4'b1111);
    send_bit(1'b1);
    tick(3);
    send_bit(1'b0);
    chk("s4_bits_with_gap", int'(bit_count), 2);
    lock_now = 1'b1;
    tick(1);
    lock_now = 1'b0;
    chk("s4_abort_bit_count", int'(bit_count), 0);
    chk("s4_abort_keeps_fail", int'(fail_count), 1);
    code_valid = 1'b1; code_in = 1'b1; lock_now = 1'b1;
    tick(1);
    code_valid = 1'b0; lock_now = 1'b0;
    chk("s4_lock_beats_bit", int'(bit_count), 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    code_valid = 1'b1; code_in = 1'b0; lock_now = 1'b1;
    tick(1);
    code_valid = 1'b0; lock_now = 1'b0;
    chk("s4_final_bit_aborted_unlocked", int'(unlocked), 0);
    chk("s4_final_bit_aborted_fail", int'(fail_count), 1);
    chk("s4_final_bit_aborted_bits", int'(bit_count), 0);
    send_bit(1'b1);
    tick(2);
    send_bit(1'b0);
    tick(3);
    send_bit(1'b1);
    send_bit(1'b0);
    expect_pulse(0, cyc, 8, 0);
    chk("s4_gap_unlock_fail", int'(fail_count), 0);
    tick(9);

    // Early relock on the 3rd unlocked cycle; bits during UNLOCKED ignored
    send_frame(4'b1010);
    expect_pulse(0, cyc, 3, 0);
    send_bit(1'b1);
    chk("s5_bits_ignored_a", int'(bit_count), 0);
    send_bit(1'b0);
    chk("s5_bits_ignored_b", int'(bit_count), 0);
    lock_now = 1'b1;
    tick(1);
    lock_now = 1'b0;
    chk("s5_relocked", int'(unlocked), 0);
    tick(1);

    // Lockout; bits and lock_now during lockout have no effect
    send_frame(4'b0000);
    chk("s3_fail1", int'(fail_count), 1);
    send_frame(4'b1111);
    chk("s3_fail2", int'(fail_count), 2);
    send_frame(4'b0110);
    k = cyc;
    expect_pulse(1, k, 16, 3);
    chk("s3_alarm_on", int'(alarm), 1);
    chk("s3_fail3", int'(fail_count), 3);
    send_frame(4'b1010);
    chk("s3_lockout_bits", int'(bit_count), 0);
    chk("s3_lockout_no_unlock", int'(unlocked), 0);
    lock_now = 1'b1;
    tick(1);
    lock_now = 1'b0;
    chk("s3_lock_now_ignored", int'(alarm), 1);
    tick(10);
    chk("s3_alarm_last_cycle", int'(alarm), 1);
    tick(1);
    chk_zero("s3_after_lockout");
    send_frame(4'b1010);
    expect_pulse(0, cyc, 8, 0);
    tick(9);

    // Reset mid-frame, in 4th unlocked cycle, and in 5th lockout cycle
    send_bit(1'b1); send_bit(1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("s6_mid_frame_bits", int'(bit_count), 0);
    send_frame(4'b1010);
    k = cyc;
    expect_pulse(0, k, 4, 0);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_zero("s6_reset_unlocked");
    send_frame(4'b0000);
    send_frame(4'b0000);
    send_frame(4'b0000);
    k = cyc;
    expect_pulse(1, k, 5, 3);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_zero("s6_reset_lockout");
    send_frame(4'b1010);
    expect_pulse(0, cyc, 8, 0);
    tick(12);

    chk("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
